// File: rtl/hamming_74_encoder_stream.sv
// Hamming(7,4) even-parity encoder with optional single-bit fault injection,
// feeding a 2-entry FIFO with saturating accept/inject counters.
module hamming_74_encoder_stream (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_data,
  input  logic        inj_en,
  input  logic [2:0]  inj_pos,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:1]  out_code,
  output logic [15:0] word_count,
  output logic [15:0] inj_count
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [7:1]  head_q, head_d;
  logic [7:1]  tail_q, tail_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [15:0] icnt_q, icnt_d;

  logic        push, pop, inj_hit;
  logic [7:1]  clean_code, inj_mask, new_code;

  assign in_ready   = (state_q != ST_FULL);
  assign out_valid  = (state_q != ST_EMPTY);
  assign out_code   = out_valid ? head_q : 7'h00;
  assign word_count = wcnt_q;
  assign inj_count  = icnt_q;

  // Encode the incoming nibble and apply the requested bit flip.
  always_comb begin
    clean_code    = '0;
    clean_code[3] = in_data[0];
    clean_code[5] = in_data[1];
    clean_code[6] = in_data[2];
    clean_code[7] = in_data[3];
    clean_code[1] = in_data[0] ^ in_data[1] ^ in_data[3];
    clean_code[2] = in_data[0] ^ in_data[2] ^ in_data[3];
    clean_code[4] = in_data[1] ^ in_data[2] ^ in_data[3];
    inj_hit       = inj_en && (inj_pos != 3'd0);
    inj_mask      = inj_hit ? (7'd1 << (inj_pos - 3'd1)) : 7'd0;
    new_code      = clean_code ^ inj_mask;
  end

  // FIFO occupancy and entry movement; head is always the oldest entry.
  always_comb begin
    push    = in_valid && in_ready;
    pop     = out_valid && out_ready;
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          head_d  = new_code;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_d = new_code;
        end else if (push) begin
          tail_d  = new_code;
          state_d = ST_FULL;
        end else if (pop) begin
          head_d  = 7'h00;
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          head_d  = tail_q;
          tail_d  = 7'h00;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        head_d  = 7'h00;
        tail_d  = 7'h00;
      end
    endcase
  end

  // Saturating counters of accepted and fault-carrying nibbles.
  always_comb begin
    wcnt_d = wcnt_q;
    icnt_d = icnt_q;
    if (push && (wcnt_q != 16'hFFFF)) wcnt_d = wcnt_q + 16'd1;
    if (push && inj_hit && (icnt_q != 16'hFFFF)) icnt_d = icnt_q + 16'd1;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      head_q  <= 7'h00;
      tail_q  <= 7'h00;
      wcnt_q  <= 16'h0000;
      icnt_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      wcnt_q  <= wcnt_d;
      icnt_q  <= icnt_d;
    end
  end

endmodule

// File: tb/tb_hamming_74_encoder_stream.sv
// Bench for hamming_74_encoder_stream: directed and random traffic
// against a queue-based reference model.
module tb_hamming_74_encoder_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        inj_en;
  logic [2:0]  inj_pos;
  logic        out_valid;
  logic        out_ready;
  logic [7:1]  out_code;
  logic [15:0] word_count;
  logic [15:0] inj_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:1] q[$];
  int unsigned m_wc = 0;
  int unsigned m_ic = 0;

  hamming_74_encoder_stream dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .inj_en     (inj_en),
    .inj_pos    (inj_pos),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .word_count (word_count),
    .inj_count  (inj_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Codeword built from position rules: data in non-power-of-two slots,
  // parity bit p covers every position whose index has bit p set.
  function automatic logic [7:1] ref_code(input logic [3:0] d,
                                          input logic ie,
                                          input logic [2:0] ip);
    int dpos[4];
    logic [7:0] c;
    logic par;
    dpos = '{3, 5, 6, 7};
    c = '0;
    for (int i = 0; i < 4; i++) c[dpos[i]] = d[i];
    for (int p = 1; p <= 4; p = p * 2) begin
      par = 1'b0;
      for (int k = 1; k <= 7; k++)
        if (((k & p) != 0) && (k != p)) par = par ^ c[k];
      c[p] = par;
    end
    if (ie && ip != 3'd0) c[ip] = ~c[ip];
    return c[7:1];
  endfunction

  task automatic step(input logic v, input logic [3:0] d, input logic ie,
                      input logic [2:0] ip, input logic ordy);
    bit push, pop;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    inj_en    = ie;
    inj_pos   = ip;
    out_ready = ordy;
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    check("out_code", {25'd0, out_code},
          {25'd0, (q.size() != 0) ? q[0] : 7'h00});
    check("word_count", {16'd0, word_count}, m_wc);
    check("inj_count", {16'd0, inj_count}, m_ic);
    push = v && (q.size() < 2);
    pop  = ordy && (q.size() != 0);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(ref_code(d, ie, ip));
      if (m_wc < 65535) m_wc++;
      if (ie && ip != 3'd0 && m_ic < 65535) m_ic++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_code", {25'd0, out_code}, 32'd0);
    check("rst_wc", {16'd0, word_count}, 32'd0);
    check("rst_ic", {16'd0, inj_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    q.delete();
    m_wc = 0;
    m_ic = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] a, b, c;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    inj_en = 1'b0; inj_pos = '0; out_ready = 1'b0;
    #2;
    check("init_out_valid", {31'd0, out_valid}, 32'd0);
    check("init_in_ready", {31'd0, in_ready}, 32'd1);
    check("init_out_code", {25'd0, out_code}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // clean encodes
    step(1'b1, 4'b1011, 1'b0, 3'd0, 1'b1);
    #1 check("clean_1011", {25'd0, out_code}, 32'h55);
    step(1'b1, 4'h0, 1'b0, 3'd0, 1'b1);
    #1 check("clean_0", {25'd0, out_code}, 32'h00);
    check("clean_0_valid", {31'd0, out_valid}, 32'd1);
    step(1'b1, 4'hF, 1'b0, 3'd0, 1'b1);
    #1 check("clean_F", {25'd0, out_code}, 32'h7F);
    step(1'b0, 4'h0, 1'b0, 3'd0, 1'b1);

    // injection
    do_reset();
    step(1'b1, 4'b1011, 1'b1, 3'd3, 1'b1);
    #1 check("inj_pos3", {25'd0, out_code}, 32'h51);
    check("inj_cnt1", {16'd0, inj_count}, 32'd1);
    step(1'b1, 4'b1011, 1'b1, 3'd0, 1'b1);
    #1 check("inj_pos0", {25'd0, out_code}, 32'h55);
    check("inj_cnt_hold", {16'd0, inj_count}, 32'd1);
    step(1'b0, 4'h0, 1'b0, 3'd0, 1'b1);

    // backpressure
    a = 4'h3; b = 4'h9; c = 4'hC;
    step(1'b1, a, 1'b0, 3'd0, 1'b0);
    step(1'b1, b, 1'b0, 3'd0, 1'b0);
    #1 check("bp_full_rdy", {31'd0, in_ready}, 32'd0);
    check("bp_head", {25'd0, out_code}, {25'd0, ref_code(a, 1'b0, 3'd0)});
    step(1'b1, c, 1'b0, 3'd0, 1'b0);
    #1 check("bp_stable", {25'd0, out_code}, {25'd0, ref_code(a, 1'b0, 3'd0)});
    step(1'b1, c, 1'b0, 3'd0, 1'b1);
    #1 check("bp_rdy_after_pop", {31'd0, in_ready}, 32'd1);
    check("bp_second", {25'd0, out_code}, {25'd0, ref_code(b, 1'b0, 3'd0)});
    step(1'b1, c, 1'b0, 3'd0, 1'b1);
    #1 check("bp_third", {25'd0, out_code}, {25'd0, ref_code(c, 1'b0, 3'd0)});
    step(1'b0, 4'h0, 1'b0, 3'd0, 1'b1);

    // streaming in ONE
    do_reset();
    for (int i = 0; i < 20; i++)
      step(1'b1, 4'($urandom_range(0, 15)), 1'b0, 3'd0, 1'b1);
    #1 check("stream_wc", {16'd0, word_count}, 32'd20);
    check("stream_one", {31'd0, in_ready & out_valid}, 32'd1);
    step(1'b0, 4'h0, 1'b0, 3'd0, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 3) != 0));

    // reset while FULL, then no stale output
    step(1'b1, 4'h5, 1'b0, 3'd0, 1'b0);
    step(1'b1, 4'h6, 1'b0, 3'd0, 1'b0);
    #1 check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    do_reset();
    step(1'b0, 4'h0, 1'b0, 3'd0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 3'd0, 1'b1);
    #1 check("post_rst_empty", {31'd0, out_valid}, 32'd0);

    // saturation
    for (int i = 0; i < 65535; i++)
      step(1'b1, 4'($urandom_range(0, 15)), 1'b1,
           3'($urandom_range(1, 7)), 1'b1);
    #1 check("sat_wc_max", {16'd0, word_count}, 32'hFFFF);
    check("sat_ic_max", {16'd0, inj_count}, 32'hFFFF);
    step(1'b1, 4'hA, 1'b1, 3'd2, 1'b1);
    #1 check("sat_wc_hold", {16'd0, word_count}, 32'hFFFF);
    check("sat_ic_hold", {16'd0, inj_count}, 32'hFFFF);
    step(1'b0, 4'h0, 1'b0, 3'd0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 3'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_74_encoder_stream.md
HAMMING_74_ENCODER_STREAM -- requirements
Module: hamming_74_encoder_stream

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  upstream nibble valid.
REQ-005 in_ready  output  1  block can accept a nibble this cycle.
REQ-006 in_data  input  4  message nibble.
REQ-007 inj_en  input  1  fault-injection enable, sampled with in_data.
REQ-008 inj_pos  input  3  codeword bit index to flip: 1..7; 0 = no flip.
REQ-009 out_valid  output  1  codeword available.
REQ-010 out_ready  input  1  downstream accepts codeword.
REQ-011 out_code  output  7, indexed [7:1]  Hamming(7,4) codeword, possibly with one injected fault.
REQ-012 word_count  output  16  count of accepted nibbles, saturating.
REQ-013 inj_count  output  16  count of accepted nibbles that carried a fault, saturating.

Function
REQ-014 Input handshake: a nibble is accepted on a rising clk edge where in_valid && in_ready.
REQ-015 Output handshake: a codeword is retired on a rising clk edge where out_valid && out_ready.
REQ-016 Bit placement (even parity):
- code[3]=d[0], code[5]=d[1], code[6]=d[2], code[7]=d[3].
- code[1]=d0^d1^d3, code[2]=d0^d2^d3, code[4]=d1^d2^d3.
REQ-017 Fault injection: when inj_en=1 and inj_pos!=0 at acceptance, the stored codeword has bit inj_pos inverted; otherwise the stored codeword is the clean codeword.
REQ-018 Encode and inject happen at acceptance; the stored value is the final out_code, and inputs are not re-sampled afterwards.
REQ-019 Storage is a 2-entry FIFO with states EMPTY (0 entries), ONE (1 entry), FULL (2 entries).
REQ-020 State transitions:
- push only: EMPTY->ONE, ONE->FULL.
- pop only: FULL->ONE, ONE->EMPTY.
- push and pop together in ONE: stays ONE.
- no push or pop: state holds.
REQ-021 in_ready = (state != FULL); it SHALL depend only on registered state, with no combinational path from out_ready.
REQ-022 In FULL, a simultaneous pop does not enable a push that cycle; in_ready rises the cycle after the pop.
REQ-023 out_valid = (state != EMPTY); out_code shows the oldest entry and is stable while out_valid && !out_ready.
REQ-024 Latency: a nibble accepted at edge N appears on out_code after edge N when the FIFO was EMPTY (one-cycle latency).
REQ-025 Ordering is strictly FIFO; no drops and no duplicates.
REQ-026 When EMPTY, out_code SHALL be 7'h00.
REQ-027 Counter update on each acceptance:
- word_count increments by 1.
- inj_count increments by 1 when inj_en && inj_pos!=0.
- both counters saturate at 16'hFFFF, with no wrap.
REQ-028 in_data, inj_en and inj_pos are ignored when no acceptance occurs.

Reset
REQ-029 rst_n low immediately forces: state=EMPTY, out_valid=0, out_code=7'h00, word_count=0, inj_count=0.
REQ-030 in_ready SHALL be 1 while in reset.
REQ-031 Reset mid-operation discards all stored entries; no codeword is emitted for them after release.
REQ-032 After rst_n deasserts, the first acceptance is possible on the first rising clk edge.

Verification
REQ-033 Clean encode: push in_data=4'b1011 (inj off), out_ready=1 -> next cycle out_valid=1, out_code=7'h55; push 4'h0 -> 7'h00; push 4'hF -> 7'h7F.
REQ-034 Injection: push 4'b1011, inj_en=1, inj_pos=3 -> out_code=7'h51, inj_count=1.
REQ-035 Injection with inj_pos=0: push 4'b1011, inj_en=1, inj_pos=0 -> out_code=7'h55 and inj_count unchanged.
REQ-036 Backpressure: hold out_ready=0 and offer 3 nibbles A,B,C -> A and B accepted, in_ready=0, out_code=code(A) stable; raise out_ready -> A, B, C emitted in order, with C accepted the cycle after the first pop.
REQ-037 Simultaneous push/pop in ONE over 20 back-to-back nibbles -> one codeword per cycle, state stays ONE, word_count=20.
REQ-038 Reset and saturation:
- assert rst_n=0 while FULL -> out_valid=0 and counters=0 with no clk edge, and no stale output after release.
- preload word_count to 16'hFFFF via 65535 pushes, then push once more -> word_count stays 16'hFFFF.
